// File: rtl/clk_mon_pkg.sv
// Shared state type and parameter defaults for the clock-wizard lock monitor.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOCK = 2'd1,
        STABILIZE = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES        = 2;
    localparam int DEF_LOCK_STABLE_CYCLES = 120;
    localparam int DEF_RST_PULSE_CYCLES   = 8;
    localparam int DEF_TIMEOUT_CYCLES     = 4096;
    localparam int DEF_CNT_W              = 8;

endpackage

// File: rtl/clk_mon_sync.sv
// N-stage flop synchronizer, all stages reset to 0. STAGES must be at least 2.
module clk_mon_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/clk_lock_monitor.sv
// Sequences clock-wizard reset and lock qualification, gating downstream reset on stable lock.
// Optional WAIT_LOCK timeout enabled by defining CLK_LOCK_MONITOR_TIMEOUT_EN.
module clk_lock_monitor
    import clk_mon_pkg::*;
#(
    parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int RST_PULSE_CYCLES   = DEF_RST_PULSE_CYCLES,
    parameter int TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W              = DEF_CNT_W
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic             locked,
    input  logic             input_clk_stopped,
    output logic             mmcm_reset,
    output logic             sys_rst_n,
    output logic             ready,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic             lock_timeout,
    output logic [2:0]       state_dbg
);

    localparam int PW = $clog2(RST_PULSE_CYCLES + 1);
    localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);

    state_t          state;
    logic [PW-1:0]   pulse_cnt;
    logic [SW-1:0]   stable_cnt;
    logic            locked_s;
    logic            stopped_s;
    logic            lock_ok;

    clk_mon_sync #(.STAGES(SYNC_STAGES)) u_sync_locked (
        .clk   (sys_clk),
        .rst_n (reset_n),
        .d     (locked),
        .q     (locked_s)
    );

    clk_mon_sync #(.STAGES(SYNC_STAGES)) u_sync_stopped (
        .clk   (sys_clk),
        .rst_n (reset_n),
        .d     (input_clk_stopped),
        .q     (stopped_s)
    );

    assign lock_ok   = locked_s & ~stopped_s;
    assign state_dbg = {1'b0, state};

`ifdef CLK_LOCK_MONITOR_TIMEOUT_EN
    localparam int DW = $clog2(TIMEOUT_CYCLES + 1);
    logic [DW-1:0] dwell_cnt;
`else
    // Timeout hardware absent; the parameter is referenced only to keep the interface uniform.
    assign lock_timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    // ready/sys_rst_n are set on the edge that enters RUN so they track the state register exactly.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            pulse_cnt     <= '0;
            stable_cnt    <= '0;
            mmcm_reset    <= 1'b1;
            ready         <= 1'b0;
            sys_rst_n     <= 1'b0;
            lock_loss_cnt <= '0;
`ifdef CLK_LOCK_MONITOR_TIMEOUT_EN
            dwell_cnt     <= '0;
            lock_timeout  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pulse_cnt == PW'(RST_PULSE_CYCLES - 1)) begin
                        state      <= WAIT_LOCK;
                        mmcm_reset <= 1'b0;
                        pulse_cnt  <= '0;
`ifdef CLK_LOCK_MONITOR_TIMEOUT_EN
                        dwell_cnt  <= '0;
`endif
                    end else begin
                        pulse_cnt <= pulse_cnt + PW'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_ok) begin
                        state      <= STABILIZE;
                        stable_cnt <= '0;
                    end
`ifdef CLK_LOCK_MONITOR_TIMEOUT_EN
                    else if (dwell_cnt == DW'(TIMEOUT_CYCLES - 1)) begin
                        lock_timeout <= 1'b1;
                        state        <= IDLE;
                        mmcm_reset   <= 1'b1;
                        pulse_cnt    <= '0;
                    end else begin
                        dwell_cnt <= dwell_cnt + DW'(1);
                    end
`endif
                end
                STABILIZE: begin
                    if (!lock_ok) begin
                        state      <= WAIT_LOCK;
                        stable_cnt <= '0;
`ifdef CLK_LOCK_MONITOR_TIMEOUT_EN
                        dwell_cnt  <= '0;
`endif
                    end else if (stable_cnt == SW'(LOCK_STABLE_CYCLES - 1)) begin
                        state     <= RUN;
                        ready     <= 1'b1;
                        sys_rst_n <= 1'b1;
                    end else begin
                        stable_cnt <= stable_cnt + SW'(1);
                    end
                end
                RUN: begin
                    if (!lock_ok) begin
                        state      <= IDLE;
                        ready      <= 1'b0;
                        sys_rst_n  <= 1'b0;
                        mmcm_reset <= 1'b1;
                        pulse_cnt  <= '0;
                        if (lock_loss_cnt != '1) begin
                            lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
